// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, data access
// type encodings, default parameter values and a small counter helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } arb_state_e;

  // Data access types, forwarded untouched to the memory port
  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_B  = 3'b010;
  localparam logic [2:0] DM_HU = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 255;

  // Width of the busy-cycle counter; comfortably covers TIMEOUT values
  localparam int unsigned CNT_W = 16;

  // Saturating increment used by the anti-starvation counter
  function automatic logic [3:0] starve_inc(input logic [3:0] cur, input logic [3:0] lim);
    if (cur >= lim) begin
      return lim;
    end else begin
      return cur + 4'd1;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Busy-cycle watchdog for the arbiter. 'load' restarts the count when a
// transaction is granted, 'en' marks each busy cycle, and 'expire' is raised
// during the LIMIT-th busy cycle. LIMIT = 0 disables expiry entirely.
module arb_timeout_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LIMIT - 32'd1);

  logic [CNT_W-1:0] cnt_r;

  // Count busy cycles since the last grant, stopping at the final value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && (cnt_r != LAST_C)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Flag the busy cycle in which the limit is reached
  always_comb begin
    if (LIMIT != 32'd0) begin
      expire = en & (cnt_r == LAST_C);
    end else begin
      expire = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency memory port between instruction fetch
// and the data stage. Data has priority, bounded by an anti-starvation
// counter; redirects discard an outstanding fetch; a busy-cycle watchdog
// raises a sticky bus error. Completion (done/rdata/stall) is combinational
// on mem_ready so the pipeline can advance in the response cycle.
// Optional macro ARB_PERF_CNT_EN adds saturating stall-cycle counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_type,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall_cnt,
  output logic [31:0]       perf_dm_stall_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_MAX);

  arb_state_e        state_r, state_s;
  logic [3:0]        starve_r, starve_s;
  logic              discard_r;
  logic [DATA_W-1:0] if_rdata_r, dm_rdata_r, resp_data_s;
  logic              grant_d_s, grant_i_s, busy_s, expire_s;
  logic              timeout_s, finish_s, if_done_s, dm_done_s;

  assign busy_s = (state_r != IDLE);

  arb_timeout_cnt #(.LIMIT(TIMEOUT)) u_busy_tmo (
    .clk    (clk),
    .rstn   (rstn),
    .load   (grant_d_s | grant_i_s),
    .en     (busy_s),
    .expire (expire_s)
  );

  // Arbitration in IDLE and completion qualifiers while busy
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    timeout_s = expire_s & ~mem_ready;
    finish_s  = busy_s & (mem_ready | expire_s);
    if (state_r == IDLE) begin
      if (dm_req && !(if_req && (starve_r == STARVE_LIM_C))) begin
        grant_d_s = 1'b1;
      end else if (if_req && !if_flush) begin
        grant_i_s = 1'b1;
      end else begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
      end
    end else begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_s = D_BUSY;
        end else if (grant_i_s) begin
          state_s = I_BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      D_BUSY, I_BUSY: begin
        if (finish_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Anti-starvation count: grows on data grants that overtake a waiting fetch
  always_comb begin
    starve_s = starve_r;
    if (grant_d_s && if_req) begin
      starve_s = starve_inc(starve_r, STARVE_LIM_C);
    end else if (grant_i_s || ((state_r == IDLE) && !if_req)) begin
      starve_s = 4'd0;
    end else begin
      starve_s = starve_r;
    end
  end

  // Completion pulses, read-data bypass and pipeline freeze outputs.
  // A flush in the response cycle also suppresses the fetch completion.
  // Stalls are gated by rstn so every output reads 0 while in reset.
  always_comb begin
    if_done_s   = (state_r == I_BUSY) & finish_s & ~discard_r & ~if_flush;
    dm_done_s   = (state_r == D_BUSY) & finish_s;
    resp_data_s = timeout_s ? {DATA_W{1'b0}} : mem_rdata;
    if_done     = if_done_s;
    dm_done     = dm_done_s;
    if (if_done_s) begin
      if_rdata = resp_data_s;
    end else begin
      if_rdata = if_rdata_r;
    end
    if (dm_done_s) begin
      dm_rdata = resp_data_s;
    end else begin
      dm_rdata = dm_rdata_r;
    end
    if_stall = rstn & if_req & ~if_done_s;
    dm_stall = rstn & dm_req & ~dm_done_s;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Memory port request: captured on grant, held stable until completion
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_type  <= DM_W;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else if (grant_d_s) begin
      mem_req   <= 1'b1;
      mem_we    <= dm_we;
      mem_type  <= dm_type;
      mem_addr  <= dm_addr;
      mem_wdata <= dm_wdata;
    end else if (grant_i_s) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_type  <= DM_W;
      mem_addr  <= if_addr;
      mem_wdata <= {DATA_W{1'b0}};
    end else if (finish_s) begin
      mem_req   <= 1'b0;
    end
  end

  // Held read data, fetch discard flag, sticky bus error and starve count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_rdata_r <= {DATA_W{1'b0}};
      dm_rdata_r <= {DATA_W{1'b0}};
      discard_r  <= 1'b0;
      bus_err    <= 1'b0;
      starve_r   <= 4'd0;
    end else begin
      if (if_done_s) begin
        if_rdata_r <= resp_data_s;
      end
      if (dm_done_s) begin
        dm_rdata_r <= resp_data_s;
      end
      if (finish_s) begin
        discard_r <= 1'b0;
      end else if ((state_r == I_BUSY) && if_flush) begin
        discard_r <= 1'b1;
      end
      if (timeout_s) begin
        bus_err <= 1'b1;
      end
      starve_r <= starve_s;
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Saturating count of cycles each pipeline side spends stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_if_stall_cnt <= 32'd0;
      perf_dm_stall_cnt <= 32'd0;
    end else begin
      if (if_stall && (perf_if_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_if_stall_cnt <= perf_if_stall_cnt + 32'd1;
      end
      if (dm_stall && (perf_dm_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_dm_stall_cnt <= perf_dm_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8). Expected
// port issues and read data are queued when requests are driven and checked
// when the arbiter issues to the port or signals completion.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req, if_flush, if_done, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done, dm_stall;
  logic [2:0]  dm_type, mem_type;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall_cnt, perf_dm_stall_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_err(bus_err)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall_cnt(perf_if_stall_cnt), .perf_dm_stall_cnt(perf_dm_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          cmp_wd;
  } iss_t;

  iss_t        iss_q[$];
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  int n_vec = 0, n_err = 0;
  int if_pulses = 0, dm_pulses = 0;
  int lat = 0;
  bit hang = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    else return {a[15:0], 16'hC35A} ^ 32'h1357_0000;
  endfunction

  task automatic exp_issue(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit cmp_wd);
    iss_t e;
    e.we = we; e.typ = typ; e.addr = addr; e.wdata = wdata; e.cmp_wd = cmp_wd;
    iss_q.push_back(e);
  endtask

  // Memory model: answers mem_req after 'lat' extra busy cycles unless hung
  initial begin
    int rcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (mem_ready || !mem_req || !rstn) begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        rcnt = 0;
      end else if (!hang) begin
        if (rcnt == lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_data(mem_addr);
        end else begin
          rcnt++;
        end
      end
    end
  end

  // Monitor: check each new port issue and each completion against the queues
  initial begin
    iss_t e;
    logic prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (iss_q.size() == 0) begin
          chk("issue_spurious", 32'(mem_req), 32'd0);
        end else begin
          e = iss_q.pop_front();
          chk("iss_addr", mem_addr, e.addr);
          chk("iss_we", 32'(mem_we), 32'(e.we));
          chk("iss_type", 32'(mem_type), 32'(e.typ));
          if (e.cmp_wd) chk("iss_wdata", mem_wdata, e.wdata);
        end
      end
      prev_req = mem_req;
      if (if_done) begin
        if_pulses++;
        if (if_q.size() == 0) chk("if_done_spurious", 32'(if_done), 32'd0);
        else chk("if_rdata", if_rdata, if_q.pop_front());
      end
      if (dm_done) begin
        dm_pulses++;
        if (dm_q.size() == 0) chk("dm_done_spurious", 32'(dm_done), 32'd0);
        else chk("dm_rdata", dm_rdata, dm_q.pop_front());
      end
    end
  end

  task automatic wait_if_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (if_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_dm_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dm_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_mem_req(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_req == lvl) begin ok = 1'b1; break; end
    end
  endtask

  // Fetch stream: n sequential fetches, if_req held high across them
  task automatic fetch_seq(input logic [31:0] a0, input int n);
    bit ok;
    for (int k = 0; k < n; k++) begin
      if_addr = a0 + 32'(k * 4);
      if_q.push_back(mem_data(if_addr));
      if_req = 1'b1;
      wait_if_done(ok);
      chk("if_done_seen", 32'(ok), 32'd1);
      @(posedge clk); #1;
    end
    if_req = 1'b0;
  endtask

  // Data stream: n sequential accesses, dm_req held high across them
  task automatic dm_seq(input logic [31:0] a0, input int n, input logic we,
                        input logic [2:0] typ, input logic [31:0] wd0, input bit zero_rsp);
    bit ok;
    for (int k = 0; k < n; k++) begin
      dm_addr  = a0 + 32'(k * 4);
      dm_we    = we;
      dm_type  = typ;
      dm_wdata = wd0 + 32'(k);
      dm_q.push_back(zero_rsp ? 32'd0 : mem_data(dm_addr));
      dm_req   = 1'b1;
      wait_dm_done(ok);
      chk("dm_done_seen", 32'(ok), 32'd1);
      @(posedge clk); #1;
    end
    dm_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int n, p0;
    rstn = 1'b0; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_type = DM_W; dm_addr = 32'd0; dm_wdata = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_dm_done", 32'(dm_done), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1;

    // Fetch only, response 3 cycles after mem_req
    lat = 3;
    p0 = if_pulses;
    exp_issue(1'b0, DM_W, 32'h100, 32'd0, 1'b0);
    fork
      fetch_seq(32'h100, 1);
      begin @(negedge clk); chk("if_stall_wait", 32'(if_stall), 32'd1); end
    join
    repeat (3) @(negedge clk);
    chk("if_done_once", 32'(if_pulses - p0), 32'd1);
    chk("if_rdata_hold", if_rdata, 32'h0050_0093);
    @(posedge clk); #1;

    // Contention: store wins, fetch follows
    lat = 1;
    exp_issue(1'b1, DM_B, 32'h2004, 32'hAB, 1'b1);
    exp_issue(1'b0, DM_W, 32'h104, 32'd0, 1'b0);
    fork
      dm_seq(32'h2004, 1, 1'b1, DM_B, 32'hAB, 1'b0);
      fetch_seq(32'h104, 1);
    join
    @(posedge clk); #1;

    // Starvation: 4 data grants, fetch, counter restarts, 4 more, fetch
    for (int k = 0; k < 4; k++) exp_issue(1'b0, DM_W, 32'h3000 + 32'(k*4), 32'h1000 + 32'(k), 1'b1);
    exp_issue(1'b0, DM_W, 32'h400, 32'd0, 1'b0);
    for (int k = 4; k < 8; k++) exp_issue(1'b0, DM_W, 32'h3000 + 32'(k*4), 32'h1000 + 32'(k), 1'b1);
    exp_issue(1'b0, DM_W, 32'h404, 32'd0, 1'b0);
    for (int k = 8; k < 10; k++) exp_issue(1'b0, DM_W, 32'h3000 + 32'(k*4), 32'h1000 + 32'(k), 1'b1);
    fork
      dm_seq(32'h3000, 10, 1'b0, DM_W, 32'h1000, 1'b0);
      fetch_seq(32'h400, 2);
    join
    @(posedge clk); #1;

    // Flush mid-fetch (lat 4) and flush coincident with mem_ready (lat 0)
    for (int v = 0; v < 2; v++) begin
      lat = (v == 0) ? 4 : 0;
      p0 = if_pulses;
      if_addr = 32'h500 + 32'(v * 64);
      exp_issue(1'b0, DM_W, if_addr, 32'd0, 1'b0);
      if_req = 1'b1;
      @(posedge clk); #1;
      if_flush = 1'b1; if_req = 1'b0;
      @(posedge clk); #1;
      if_flush = 1'b0;
      wait_mem_req(1'b0, ok);
      chk("flush_req_drop", 32'(ok), 32'd1);
      repeat (2) @(negedge clk);
      chk("flush_no_done", 32'(if_pulses - p0), 32'd0);
      chk("flush_rdata_hold", if_rdata, mem_data(32'h404));
      @(posedge clk); #1;
    end
    lat = 1;
    exp_issue(1'b0, DM_W, 32'h600, 32'd0, 1'b0);
    fetch_seq(32'h600, 1);
    @(posedge clk); #1;

    // Timeout: hung load completes with zero data after 8 busy cycles
    hang = 1'b1;
    exp_issue(1'b0, DM_W, 32'h7000, 32'h55, 1'b1);
    fork
      dm_seq(32'h7000, 1, 1'b0, DM_W, 32'h55, 1'b1);
      begin
        wait_mem_req(1'b1, ok);
        n = 1;
        while (!dm_done && n < 50) begin @(negedge clk); n++; end
        chk("tmo_busy_cycles", 32'(n), 32'd8);
      end
    join
    @(negedge clk);
    chk("bus_err_set", 32'(bus_err), 32'd1);
    hang = 1'b0; lat = 0;
    exp_issue(1'b0, DM_H, 32'h7100, 32'h66, 1'b1);
    dm_seq(32'h7100, 1, 1'b0, DM_H, 32'h66, 1'b0);
    @(negedge clk);
    chk("bus_err_sticky", 32'(bus_err), 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a data transaction
    hang = 1'b1;
    exp_issue(1'b0, DM_W, 32'h7200, 32'h77, 1'b1);
    dm_addr = 32'h7200; dm_we = 1'b0; dm_type = DM_W; dm_wdata = 32'h77; dm_req = 1'b1;
    wait_mem_req(1'b1, ok);
    chk("rst_mid_issue", 32'(ok), 32'd1);
    p0 = dm_pulses;
    #2 rstn = 1'b0;
    #1;
    chk("rmid_mem_req", 32'(mem_req), 32'd0);
    chk("rmid_dm_done", 32'(dm_done), 32'd0);
    chk("rmid_dm_stall", 32'(dm_stall), 32'd0);
    chk("rmid_bus_err", 32'(bus_err), 32'd0);
    chk("rmid_dm_rdata", dm_rdata, 32'd0);
    chk("rmid_mem_addr", mem_addr, 32'd0);
    dm_req = 1'b0; hang = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rstn = 1'b1;
    repeat (8) @(negedge clk);
    chk("rmid_no_done", 32'(dm_pulses - p0), 32'd0);
    chk("rmid_idle", 32'(mem_req), 32'd0);

    chk("iss_q_left", 32'(iss_q.size()), 32'd0);
    chk("if_q_left", 32'(if_q.size()), 32'd0);
    chk("dm_q_left", 32'(dm_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory port between instruction fetch (IF) and the data-memory stage (MEM: loads and stores).
- Sits between the pipeline and the unified memory, and drives pipeline freeze signals.
- Uses fixed data-over-fetch priority with an anti-starvation counter, fetch flush/discard on redirect, and a response timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits; range 1..15.
- TIMEOUT, 255, max busy cycles before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, level; held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  redirect; cancels a pending or outstanding fetch.
- if_done  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- if_stall  out  1  if_req & ~if_done.
- dm_req  in  1  data request, level; held until dm_done.
- dm_we  in  1  1 = store.
- dm_type  in  3  000 w, 001 h, 010 b, 011 hu, 100 bu.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_done  out  1  one-cycle pulse; access complete, dm_rdata valid for loads.
- dm_rdata  out  DATA_W  load data, passed through unmodified.
- dm_stall  out  1  dm_req & ~dm_done.
- mem_req  out  1  port request; held until mem_ready.
- mem_we  out  1  port write enable.
- mem_type  out  3  port access type.
- mem_addr  out  ADDR_W  port address.
- mem_wdata  out  DATA_W  port write data.
- mem_ready  in  1  port response; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  port read data.
- bus_err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; all outputs 0; starve counter 0; discard flag 0.
  - Reset asserted mid-transaction abandons it; no done pulse is issued.
- States: IDLE, D_BUSY, I_BUSY.
- IDLE arbitration, sampled each cycle:
  - Grant data if dm_req & ~(if_req & starve==STARVE_MAX).
  - Else grant fetch if if_req & ~if_flush.
  - On grant, register address/we/type/wdata into the mem_* outputs and go to the BUSY state; mem_req=1 from the next cycle.
  - Fetch requests always use mem_we=0, mem_type=000.
- Starve counter:
  - Increments on each data grant while if_req=1, saturating at STARVE_MAX.
  - Clears on a fetch grant, or on any IDLE cycle with if_req=0.
- BUSY states:
  - mem_* outputs are held stable until mem_ready.
  - On mem_ready: capture mem_rdata into if_rdata or dm_rdata, pulse the matching done signal, drop mem_req, return to IDLE.
- Minimum latency: request sampled in cycle N, mem_req in N+1, done at the earliest in N+1 if mem_ready arrives immediately.
- Back-to-back: IDLE is visited for one cycle between transactions.
- if_flush:
  - In I_BUSY, sets the discard flag; the response is consumed with no if_done pulse and the flag clears.
  - In IDLE, blocks the fetch grant that cycle only.
  - if_flush and mem_ready in the same I_BUSY cycle: discard the response.
  - if_flush has no effect on data transactions.
- if_rdata and dm_rdata hold their last value between done pulses.
- Timeout (TIMEOUT != 0):
  - A busy-cycle counter resets on entry to a BUSY state.
  - Reaching TIMEOUT without mem_ready: set bus_err, pulse the matching done signal with rdata=0, drop mem_req, return to IDLE.
- Simultaneous if_req and dm_req with starve<STARVE_MAX: data wins.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds outputs perf_if_stall_cnt and perf_dm_stall_cnt (32 bits each).
  - Each increments on every cycle its stall output is 1.
  - Both saturate at all-ones; both reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state enum (IDLE, D_BUSY, I_BUSY);
  - dm_type encodings (DM_W, DM_H, DM_B, DM_HU, DM_BU);
  - default parameter constants.
- One sub-module: arb_timeout_cnt (load/enable/expire), reused for the busy counter.
- Perf counters stay inline.

Test Plan:
- Fetch only: if_addr=0x100, mem_ready 3 cycles after mem_req -> if_done once, if_rdata=mem_rdata=0x00500093, mem_type=000, mem_we=0.
- Contention: if_req and dm_req (store, dm_type=010, addr 0x2004, wdata 0xAB) both high in the same cycle -> data transaction first with mem_we=1, mem_type=010; fetch follows after one IDLE cycle.
- Starvation: dm_req continuously high with if_req high, STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant, then the counter restarts.
- Flush: if_flush pulsed during I_BUSY, then mem_ready -> no if_done pulse, if_rdata unchanged; the next fetch completes normally.
- Timeout: TIMEOUT=8, mem_ready held 0 on a load -> dm_done after 8 busy cycles, dm_rdata=0, bus_err=1 until rstn falls.
- Reset mid-transaction: rstn low during D_BUSY -> all outputs 0 immediately; no done pulse after release.
